// File: rtl/rp_slot_sequencer.sv
// rp_slot_sequencer: per-slot RP clock-enable/reset power sequencer; optional lock monitor via RP_SEQ_LOCK_MONITOR_EN
module rp_slot_sequencer #(
  parameter int CLKEN_SETTLE_CYCLES = 4,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clken_req,
  input  logic       resetn_req,
  input  logic       decouple_status,
  input  logic       rp_clk_locked,
  output logic       slot_clken,
  output logic       slot_resetn,
  output logic       seq_busy,
  output logic [2:0] seq_state,
  output logic       lock_fault
);
  typedef enum logic [2:0] {
    OFF        = 3'd0,
    CLK_SETTLE = 3'd1,
    RST_HOLD   = 3'd2,
    RUN        = 3'd3,
    RST_ENTER  = 3'd4,
    CLK_GATE   = 3'd5
  } state_t;
  localparam logic [CNT_WIDTH-1:0] SETTLE_LD = CNT_WIDTH'(CLKEN_SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LD = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  state_t state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0] dec_sync;
  logic dec_s, lk, stop, cnt_zero;
  // two-flop synchronizer for the decoupler status
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) dec_sync <= '0;
    else dec_sync <= {dec_sync[0], decouple_status};
  assign dec_s = dec_sync[1];
`ifdef RP_SEQ_LOCK_MONITOR_EN
  logic [2:0] lock_sync;
  // lock synchronizer; the extra top bit keeps the previous lock_s for fall detection
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lock_sync <= '0;
    else lock_sync <= {lock_sync[1:0], rp_clk_locked};
  assign lk = lock_sync[1];
  // sticky lock-loss flag, set dominates the OFF-idle clear
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lock_fault <= 1'b0;
    else if (lock_sync[2] & ~lock_sync[1] & (state != OFF)) lock_fault <= 1'b1;
    else if ((state == OFF) & ~clken_req) lock_fault <= 1'b0;
`else
  logic unused_lock;
  assign unused_lock = rp_clk_locked;
  assign lk = 1'b1;
  assign lock_fault = 1'b0;
`endif
  assign stop = ~clken_req | ~lk;
  assign cnt_zero = cnt == '0;
  // sequencing FSM; clock enable and reset are registered here so they never glitch
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= OFF;
      cnt <= '0;
      slot_clken <= 1'b0;
      slot_resetn <= 1'b0;
    end else begin
      case (state)
        OFF:
          if (clken_req & lk & ~dec_s) begin
            state <= CLK_SETTLE;
            cnt <= SETTLE_LD;
            slot_clken <= 1'b1;
          end
        CLK_SETTLE:
          if (stop) begin
            state <= CLK_GATE;
            cnt <= SETTLE_LD;
            slot_clken <= 1'b0;
            slot_resetn <= 1'b0;
          end else if (cnt_zero) begin
            state <= RST_HOLD;
            cnt <= HOLD_LD;
          end else cnt <= cnt - 1'b1;
        RST_HOLD:
          if (stop) begin
            state <= CLK_GATE;
            cnt <= SETTLE_LD;
            slot_clken <= 1'b0;
            slot_resetn <= 1'b0;
          end else if (cnt_zero & resetn_req & ~dec_s) begin
            state <= RUN;
            slot_resetn <= 1'b1;
          end else if (!cnt_zero) cnt <= cnt - 1'b1;
        RUN:
          if (~resetn_req | dec_s | stop) begin
            state <= RST_ENTER;
            cnt <= HOLD_LD;
            slot_resetn <= 1'b0;
          end
        RST_ENTER:
          if (cnt_zero) state <= RST_HOLD;
          else cnt <= cnt - 1'b1;
        CLK_GATE:
          if (cnt_zero) state <= OFF;
          else cnt <= cnt - 1'b1;
        default: begin
          state <= CLK_GATE;
          cnt <= SETTLE_LD;
          slot_clken <= 1'b0;
          slot_resetn <= 1'b0;
        end
      endcase
    end
  assign seq_state = state;
  assign seq_busy = (state == CLK_SETTLE) | (state == RST_ENTER) | (state == CLK_GATE) | ((state == RST_HOLD) & ~cnt_zero);
endmodule
